// File: rtl/regfile_onehot_bank.sv
// rtl/regfile_onehot_bank.sv - register file fed by one-hot write enables, XZR at top index, multi-hot detection
// Optional write-through bypass on the read ports when REGFILE_WR_BYPASS_EN is defined.
module regfile_onehot_bank #(
  parameter int WIDTH  = 64,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NREGS-1:0]  i_wren,
  input  logic [WIDTH-1:0]  i_wrdata,
  input  logic [ADDR_W-1:0] i_rdaddr1,
  input  logic [ADDR_W-1:0] i_rdaddr2,
  output logic [WIDTH-1:0]  o_rddata1,
  output logic [WIDTH-1:0]  o_rddata2,
  output logic              o_onehot_err,
  output logic [15:0]       o_wr_count
);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic             r_onehot_err;
  logic [15:0]      r_wr_count;

  logic [NREGS-1:0] w_wren_m1;
  logic             w_multi;
  logic             w_single;
  logic             w_commit;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;

  // x & (x-1) is nonzero exactly when two or more bits are set.
  assign w_wren_m1 = i_wren - {{(NREGS-1){1'b0}}, 1'b1};
  assign w_multi   = |(i_wren & w_wren_m1);
  assign w_single  = (|i_wren) & ~w_multi;
  assign w_commit  = w_single & ~i_wren[NREGS-1];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_onehot_err <= 1'b0;
      r_wr_count   <= '0;
    end else begin
      if (w_multi) r_onehot_err <= 1'b1;
      if (w_commit) begin
        r_wr_count <= r_wr_count + 16'd1;
        for (int i = 0; i < NREGS - 1; i++) begin
          if (i_wren[i]) r_regs[i] <= i_wrdata;
        end
      end
    end
  end

  // XZR is the all-ones index since NREGS == 2**ADDR_W.
  assign w_rd1 = (&i_rdaddr1) ? '0 : r_regs[i_rdaddr1];
  assign w_rd2 = (&i_rdaddr2) ? '0 : r_regs[i_rdaddr2];

`ifdef REGFILE_WR_BYPASS_EN
  logic w_byp1;
  logic w_byp2;
  // w_commit already excludes XZR and multi-hot, so a hit here is never index NREGS-1.
  assign w_byp1 = w_commit & i_wren[i_rdaddr1] & ~i_reset;
  assign w_byp2 = w_commit & i_wren[i_rdaddr2] & ~i_reset;
  assign o_rddata1 = w_byp1 ? i_wrdata : w_rd1;
  assign o_rddata2 = w_byp2 ? i_wrdata : w_rd2;
`else
  assign o_rddata1 = w_rd1;
  assign o_rddata2 = w_rd2;
`endif

  assign o_onehot_err = r_onehot_err;
  assign o_wr_count   = r_wr_count;

endmodule
